latch_phase_gen: RTL and testbench
==================================

Name: latch_phase_gen

Overview:
- Driver side of the complementary-enable latch cells (D_LATCH CLK/nCLK, TINV EN/nEN).
- Generates two non-overlapping clock phases, PH1/nPH1 and PH2/nPH2, from one system clock, for master/slave latch pairs and tri-state buses.
- Supports free-run and single-step operation, so the board can be stepped by hand while the LED probes are read.

Parameters:
- ACT_CYC, 4: clocks each phase stays asserted; must be >=1.
- DEAD_CYC, 1: clocks both phases stay inactive between phases; must be >=1.
- CNT_W, 16: width of the completed-cycle counter.

Ports:
- CLK  in  1  system clock; everything updates on the rising edge.
- nRST  in  1  synchronous reset, active-low.
- RUN  in  1  level; while high, the generator cycles continuously.
- STEP  in  1  sampled only in IDLE; a high sample requests exactly one full cycle.
- PH1  out  1  phase-1 enable, active-high.
- nPH1  out  1  complement of PH1.
- PH2  out  1  phase-2 enable, active-high.
- nPH2  out  1  complement of PH2.
- IDLE  out  1  high while the generator is stopped.
- DONE  out  1  one-clock pulse when a cycle ends and the generator enters IDLE.
- CYC_CNT  out  CNT_W  completed-cycle count; present only with the optional feature.

Behaviour:
- One clock domain. Reset is synchronous and active-low on nRST, sampled on the CLK rising edge.
- Reset values: PH1=0, PH2=0, nPH1=1, nPH2=1, IDLE=1, DONE=0, CYC_CNT=0.
- Reset asserted mid-phase takes effect at the next edge with no completion of the phase.
- State register is one-hot: IDLE, P1, D1, P2, D2, plus a duration counter.
- Outputs are direct decodes of flops, so they are glitch-free:
  - PH1 = (state==P1), nPH1 = ~PH1.
  - PH2 = (state==P2), nPH2 = ~PH2.
  - Each pair comes from complementary flops updated on the same edge; at no clock are PH1 and PH2 both 1.
- IDLE -> P1: at an edge where RUN=1 or STEP=1 is sampled. PH1 is high in the clock period that follows that edge.
- P1 -> D1 after ACT_CYC clocks.
- D1 -> P2 after DEAD_CYC clocks.
- P2 -> D2 after ACT_CYC clocks.
- D2 -> P1 after DEAD_CYC clocks if RUN=1 at that edge, with no idle clock in between.
- D2 -> IDLE after DEAD_CYC clocks if RUN=0 at that edge; DONE=1 for exactly the first clock in IDLE.
- Full cycle length: 2*(ACT_CYC+DEAD_CYC) clocks; 10 clocks at the defaults.
- RUN dropped mid-cycle: the cycle is never truncated; it finishes D2, then goes to IDLE with DONE.
- STEP outside IDLE: ignored, not queued. STEP held high across IDLE repeats cycles, behaving like RUN.
- RUN and STEP both high in IDLE: same as RUN.
- Duration counter reloads on every state entry. Its width is clog2(max(ACT_CYC,DEAD_CYC))+1.
- ACT_CYC=0 or DEAD_CYC=0: elaboration error via a generate-time check.

Optional Feature:
- Macro: LATCH_PHASE_GEN_CYCCNT_EN.
- Defined:
  - CYC_CNT port and counter are present.
  - Counter increments by 1 on each P2->D2 transition and wraps from 2^CNT_W-1 to 0.
  - nRST clears it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold nRST=0 for 3 clocks with RUN=1 -> PH1=PH2=0, nPH1=nPH2=1, IDLE=1, DONE=0, CYC_CNT=0 throughout.
- Free-run at defaults: RUN=1 from clock 0 for 40 clocks ->
  - PH1 high in clocks 1-4 and 11-14.
  - PH2 high in clocks 6-9 and 16-19.
  - PH1&PH2 never 1 together; nPHx == ~PHx every clock.
  - CYC_CNT = 4 at clock 41 with the macro defined.
- Single step: 1-clock STEP pulse in IDLE -> exactly one 10-clock cycle, then IDLE=1 and DONE=1 for one clock.
  - A second STEP at clock 5 is ignored: no extra cycle.
- RUN drop mid-cycle: RUN falls while in P1 -> P2 still completes 4 clocks, D2 1 clock, then IDLE with DONE.
- Reset mid-P2: nRST=0 sampled in the 2nd clock of P2 -> next clock PH2=0, nPH2=1, IDLE=1, no DONE pulse, CYC_CNT=0.
- Parameter/wrap: ACT_CYC=1, DEAD_CYC=2, CNT_W=2 -> 6-clock cycle; CYC_CNT sequence 1,2,3,0 over 4 cycles.

Source files
------------

// File: rtl/latch_phase_gen.sv
// rtl/latch_phase_gen.sv - two-phase non-overlapping latch enable generator
// Optional completed-cycle counter on CYC_CNT under macro LATCH_PHASE_GEN_CYCCNT_EN.
module latch_phase_gen #(
    parameter int ACT_CYC  = 4,
    parameter int DEAD_CYC = 1,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             RUN,
    input  logic             STEP,
    output logic             PH1,
    output logic             nPH1,
    output logic             PH2,
    output logic             nPH2,
    output logic             IDLE,
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
    output logic [CNT_W-1:0] CYC_CNT,
`endif
    output logic             DONE
);

    localparam int MAX_CYC = (ACT_CYC > DEAD_CYC) ? ACT_CYC : DEAD_CYC;
    localparam int DW      = $clog2(MAX_CYC) + 1;
    localparam logic [DW-1:0] ACT_LD  = DW'(ACT_CYC - 1);
    localparam logic [DW-1:0] DEAD_LD = DW'(DEAD_CYC - 1);

    generate
        if (ACT_CYC < 1 || DEAD_CYC < 1) begin : g_param_err
            $error("latch_phase_gen: ACT_CYC and DEAD_CYC must both be >= 1");
        end
    endgenerate

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_P1   = 5'b00010,
        S_D1   = 5'b00100,
        S_P2   = 5'b01000,
        S_D2   = 5'b10000
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   dur_q, dur_d;
    logic            done_q, done_d;
    logic            ph1_q, nph1_q, ph2_q, nph2_q;
    logic            cyc_inc;

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q - DW'(1);
        done_d  = 1'b0;
        cyc_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                dur_d = '0;
                if (RUN || STEP) begin
                    state_d = S_P1;
                    dur_d   = ACT_LD;
                end
            end
            S_P1: if (dur_q == '0) begin
                state_d = S_D1;
                dur_d   = DEAD_LD;
            end
            S_D1: if (dur_q == '0) begin
                state_d = S_P2;
                dur_d   = ACT_LD;
            end
            S_P2: if (dur_q == '0) begin
                state_d = S_D2;
                dur_d   = DEAD_LD;
                cyc_inc = 1'b1;
            end
            S_D2: if (dur_q == '0) begin
                // STEP is deliberately not looked at here: only RUN chains cycles
                if (RUN) begin
                    state_d = S_P1;
                    dur_d   = ACT_LD;
                end else begin
                    state_d = S_IDLE;
                    dur_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                dur_d   = '0;
            end
        endcase
    end

    // Phase outputs and their complements are each their own flop, all fed from state_d
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            dur_q   <= '0;
            done_q  <= 1'b0;
            ph1_q   <= 1'b0;
            nph1_q  <= 1'b1;
            ph2_q   <= 1'b0;
            nph2_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            done_q  <= done_d;
            ph1_q   <= (state_d == S_P1);
            nph1_q  <= (state_d != S_P1);
            ph2_q   <= (state_d == S_P2);
            nph2_q  <= (state_d != S_P2);
        end
    end

`ifdef LATCH_PHASE_GEN_CYCCNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else if (cyc_inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign CYC_CNT = cnt_q;
`endif

    assign PH1  = ph1_q;
    assign nPH1 = nph1_q;
    assign PH2  = ph2_q;
    assign nPH2 = nph2_q;
    assign IDLE = state_q[0];
    assign DONE = done_q;

endmodule

// File: tb/tb_latch_phase_gen.sv
// tb/tb_latch_phase_gen.sv - directed vector bench for latch_phase_gen
// Counter checks are compiled in only with LATCH_PHASE_GEN_CYCCNT_EN.
module tb_latch_phase_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nrst, run, step;
    logic ph1, nph1, ph2, nph2, idle, done;
    logic nrst2, run2, step2;
    logic ph1b, nph1b, ph2b, nph2b, idleb, doneb;
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
    logic [15:0] cnt;
    logic [1:0]  cntb;
`endif

    latch_phase_gen u_dut (
        .CLK(clk), .nRST(nrst), .RUN(run), .STEP(step),
        .PH1(ph1), .nPH1(nph1), .PH2(ph2), .nPH2(nph2), .IDLE(idle),
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
        .CYC_CNT(cnt),
`endif
        .DONE(done)
    );

    latch_phase_gen #(.ACT_CYC(1), .DEAD_CYC(2), .CNT_W(2)) u_small (
        .CLK(clk), .nRST(nrst2), .RUN(run2), .STEP(step2),
        .PH1(ph1b), .nPH1(nph1b), .PH2(ph2b), .nPH2(nph2b), .IDLE(idleb),
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
        .CYC_CNT(cntb),
`endif
        .DONE(doneb)
    );

    typedef struct packed {
        logic run;
        logic step;
        logic ph1;
        logic ph2;
        logic idle;
        logic done;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0d: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic add_n(input int n, input logic r, input logic s, input logic p1,
                         input logic p2, input logic id, input logic dn);
        vec_t v;
        v = '{run: r, step: s, ph1: p1, ph2: p2, idle: id, done: dn};
        for (int i = 0; i < n; i++) vt.push_back(v);
    endtask

    task automatic chk_main(input string tag, input int idx, input logic p1, input logic p2,
                            input logic id, input logic dn);
        chk({tag, ".ph1"}, idx, {31'd0, ph1}, {31'd0, p1});
        chk({tag, ".nph1"}, idx, {31'd0, nph1}, {31'd0, ~p1});
        chk({tag, ".ph2"}, idx, {31'd0, ph2}, {31'd0, p2});
        chk({tag, ".nph2"}, idx, {31'd0, nph2}, {31'd0, ~p2});
        chk({tag, ".idle"}, idx, {31'd0, idle}, {31'd0, id});
        chk({tag, ".done"}, idx, {31'd0, done}, {31'd0, dn});
    endtask

    initial begin
        logic [1:0] exp_wrap [4];
        exp_wrap[0] = 2'd1; exp_wrap[1] = 2'd2; exp_wrap[2] = 2'd3; exp_wrap[3] = 2'd0;

        // Free run: entries 1-20 two full cycles, 21 chains into a third, RUN drops in P1 at 22
        for (int c = 0; c < 2; c++) begin
            add_n(4, 1, 0, 1, 0, 0, 0);
            add_n(1, 1, 0, 0, 0, 0, 0);
            add_n(4, 1, 0, 0, 1, 0, 0);
            add_n(1, 1, 0, 0, 0, 0, 0);
        end
        add_n(1, 1, 0, 1, 0, 0, 0);
        add_n(3, 0, 0, 1, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 0, 0);
        add_n(4, 0, 0, 0, 1, 0, 0);
        add_n(1, 0, 0, 0, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 1, 1);
        add_n(1, 0, 0, 0, 0, 1, 0);
        // Single step, with a second STEP at clock 5 that must be ignored
        add_n(1, 0, 1, 1, 0, 0, 0);
        add_n(3, 0, 0, 1, 0, 0, 0);
        add_n(1, 0, 1, 0, 0, 0, 0);
        add_n(4, 0, 0, 0, 1, 0, 0);
        add_n(1, 0, 0, 0, 0, 0, 0);
        add_n(1, 0, 0, 0, 0, 1, 1);
        add_n(2, 0, 0, 0, 0, 1, 0);

        nrst = 1'b0; run = 1'b1; step = 1'b0;
        nrst2 = 1'b0; run2 = 1'b0; step2 = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_main("reset", i, 0, 0, 1, 0);
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
            chk("reset.cnt", i, {16'd0, cnt}, 32'd0);
`endif
        end
        nrst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            run  = vt[i].run;
            step = vt[i].step;
            @(posedge clk); #1;
            chk_main("vec", i + 1, vt[i].ph1, vt[i].ph2, vt[i].idle, vt[i].done);
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
            if (i == 29) chk("vec.cnt3", i + 1, {16'd0, cnt}, 32'd3);
`endif
        end
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
        chk("cnt.after_step", 0, {16'd0, cnt}, 32'd4);
`endif

        // Reset sampled in the second clock of P2
        run = 1'b1; step = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk_main("midp2.pre", 7, 0, 1, 0, 0);
        nrst = 1'b0;
        @(posedge clk); #1;
        chk_main("midp2.rst", 8, 0, 0, 1, 0);
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
        chk("midp2.cnt", 8, {16'd0, cnt}, 32'd0);
`endif
        nrst = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        chk_main("midp2.after", 9, 0, 0, 1, 0);

        // Short-parameter instance: 6-clock cycle and 2-bit counter wrap
        nrst2 = 1'b1; run2 = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            chk("small.ph1", k, {31'd0, ph1b}, {31'd0, (k % 6) == 1});
            chk("small.ph2", k, {31'd0, ph2b}, {31'd0, (k % 6) == 4});
            chk("small.idle", k, {31'd0, idleb}, 32'd0);
`ifdef LATCH_PHASE_GEN_CYCCNT_EN
            if ((k % 6) == 5) chk("small.cnt", k, {30'd0, cntb}, {30'd0, exp_wrap[k / 6]});
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
